// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: source/destination bit indices,
// load types and the WB state type.
package wb_stage_pkg;

  localparam int RF_FROM_MEM     = 0;
  localparam int RF_FROM_ALU     = 1;
  localparam int RF_FROM_PCPLUS8 = 2;
  localparam int RF_FROM_MD      = 3;

  localparam int RF_IN_RD = 0;
  localparam int RF_IN_RT = 1;
  localparam int RF_IN_RA = 2;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_GO      = 2'd1,
    ST_WAIT_MD = 2'd2
  } ws_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake, MD result, register-file write port and forwarding bus.
// The master side is MEM/decode/MD; the slave side is the WB stage.
interface wb_stage_if #(
  parameter int NSRC  = 5,
  parameter int RF_AW = 5
);
  localparam int EXT_W = (NSRC > 4) ? 32 * (NSRC - 4) : 32;

  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [31:0]       ms_pc;
  logic [NSRC-1:0]   ms_rfsrc;
  logic [2:0]        ms_rfdst;
  logic [RF_AW-1:0]  ms_rd;
  logic [RF_AW-1:0]  ms_rt;
  logic [31:0]       ms_alu_result;
  logic [31:0]       ms_mem_data;
  logic [2:0]        ms_ld_type;
  logic [EXT_W-1:0]  ms_ext_data;
  logic [31:0]       md_data;
  logic              md_ready;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [31:0]       rf_wdata;
  logic              ws_fwd_valid;
  logic              ws_fwd_ok;
  logic [RF_AW-1:0]  ws_fwd_addr;
  logic [31:0]       ws_fwd_data;
  logic [31:0]       ws_pc;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_rfsrc, ms_rfdst, ms_rd, ms_rt,
           ms_alu_result, ms_mem_data, ms_ld_type, ms_ext_data, md_data, md_ready,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ws_fwd_valid, ws_fwd_ok,
           ws_fwd_addr, ws_fwd_data, ws_pc
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_rfsrc, ms_rfdst, ms_rd, ms_rt,
           ms_alu_result, ms_mem_data, ms_ld_type, ms_ext_data, md_data, md_ready,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ws_fwd_valid, ws_fwd_ok,
           ws_fwd_addr, ws_fwd_data, ws_pc
  );
endinterface

// File: rtl/wb_ld_align.sv
// Extracts the addressed byte/halfword of a load word and sign/zero-extends it.
// Purely combinational; unknown load types pass the word through.
module wb_ld_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (addr)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    // Halfword loads use only addr[1]; a misaligned addr[0] is ignored.
    half_v = addr[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_B:    data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   data = {24'd0, byte_v};
      LD_H:    data = {{16{half_v[15]}}, half_v};
      LD_HU:   data = {16'd0, half_v};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// One-entry write-back register: selects write data, suppresses $0 writes,
// holds MD-sourced instructions until md_ready, and exports a forwarding bus.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int NSRC  = 5,
  parameter int RF_AW = 5
) (
  input  logic         clk,
  input  logic         resetn,
  wb_stage_if.slave    bus
);
  localparam int EXT_W = (NSRC > 4) ? 32 * (NSRC - 4) : 32;

  ws_state_t         state_q, state_d;
  logic [31:0]       pc_q, alu_q, mem_q, md_q;
  logic [NSRC-1:0]   src_q;
  logic [2:0]        dst_q;
  logic [RF_AW-1:0]  rd_q, rt_q;
  logic [2:0]        ld_q;
  logic [EXT_W-1:0]  ext_q;

  logic              ws_valid, ready_go, allowin, capture, wr_ok;
  logic [31:0]       ld_val, md_src, wdata;
  logic [RF_AW-1:0]  waddr;

  assign ws_valid = (state_q != ST_EMPTY);
  assign ready_go = (state_q == ST_GO) || ((state_q == ST_WAIT_MD) && bus.md_ready);
  assign allowin  = !ws_valid || ready_go;
  assign capture  = bus.ms_to_ws_valid && allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // A retiring entry and the next capture share one edge.
  always_comb begin
    state_d = state_q;
    if (capture)       state_d = bus.ms_rfsrc[RF_FROM_MD] ? ST_WAIT_MD : ST_GO;
    else if (ready_go) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q  <= '0;
      alu_q <= '0;
      mem_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      rd_q  <= '0;
      rt_q  <= '0;
      ld_q  <= '0;
      ext_q <= '0;
      md_q  <= '0;
    end else begin
      if (capture) begin
        pc_q  <= bus.ms_pc;
        alu_q <= bus.ms_alu_result;
        mem_q <= bus.ms_mem_data;
        src_q <= bus.ms_rfsrc;
        dst_q <= bus.ms_rfdst;
        rd_q  <= bus.ms_rd;
        rt_q  <= bus.ms_rt;
        ld_q  <= bus.ms_ld_type;
        ext_q <= bus.ms_ext_data;
      end
      if ((state_q == ST_WAIT_MD) && bus.md_ready) md_q <= bus.md_data;
    end
  end

  wb_ld_align u_ld_align (
    .ld_type (ld_q),
    .addr    (alu_q[1:0]),
    .word    (mem_q),
    .data    (ld_val)
  );

  // Retirement out of WAIT_MD happens in the md_ready cycle, so use the live value.
  assign md_src = (state_q == ST_WAIT_MD) ? bus.md_data : md_q;

  always_comb begin
    wdata = 32'd0;
    if (src_q[RF_FROM_MEM])     wdata = wdata | ld_val;
    if (src_q[RF_FROM_ALU])     wdata = wdata | alu_q;
    if (src_q[RF_FROM_PCPLUS8]) wdata = wdata | (pc_q + 32'd8);
    if (src_q[RF_FROM_MD])      wdata = wdata | md_src;
    for (int k = 0; k < NSRC - 4; k++) begin
      if (src_q[4+k]) wdata = wdata | ext_q[32*k +: 32];
    end
  end

  always_comb begin
    waddr = '0;
    if (dst_q[RF_IN_RD]) waddr = waddr | rd_q;
    if (dst_q[RF_IN_RT]) waddr = waddr | rt_q;
    if (dst_q[RF_IN_RA]) waddr = waddr | RF_AW'(31);
  end

  assign wr_ok = (dst_q != 3'd0) && (waddr != '0);

  assign bus.ws_allowin   = allowin;
  assign bus.rf_we        = ws_valid && ready_go && wr_ok;
  assign bus.rf_waddr     = waddr;
  assign bus.rf_wdata     = wdata;
  assign bus.ws_fwd_valid = ws_valid && wr_ok;
  assign bus.ws_fwd_ok    = ready_go;
  assign bus.ws_fwd_addr  = waddr;
  assign bus.ws_fwd_data  = wdata;
  assign bus.ws_pc        = pc_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, multi-cycle sequences and a
// randomized stream scored against a spec-level reference model.
module tb_wb_stage;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  wb_stage_if #(.NSRC(5), .RF_AW(5)) bus ();
  wb_stage #(.NSRC(5), .RF_AW(5)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  ld;
    logic [31:0] pc, alu, mem, ext;
    logic [4:0]  src;
    logic [2:0]  dst;
    logic [4:0]  rd, rt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        md;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ld, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] ext, input logic [4:0] src,
                       input logic [2:0] dst, input logic [4:0] rd, input logic [4:0] rt);
    bus.ms_ld_type    = ld;
    bus.ms_pc         = pc;
    bus.ms_alu_result = alu;
    bus.ms_mem_data   = mem;
    bus.ms_ext_data   = ext;
    bus.ms_rfsrc      = src;
    bus.ms_rfdst      = dst;
    bus.ms_rd         = rd;
    bus.ms_rt         = rt;
  endtask

  // Starts and ends at posedge+1 with WB empty.
  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.ld, v.pc, v.alu, v.mem, v.ext, v.src, v.dst, v.rd, v.rt);
    bus.ms_to_ws_valid = 1'b1;
    step();
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_we", idx), 32'(bus.rf_we), 32'(v.we));
    check($sformatf("v%0d_waddr", idx), 32'(bus.rf_waddr), 32'(v.waddr));
    check($sformatf("v%0d_wdata", idx), bus.rf_wdata, v.wdata);
    check($sformatf("v%0d_fwd_valid", idx), 32'(bus.ws_fwd_valid), 32'(v.we));
    check($sformatf("v%0d_allowin", idx), 32'(bus.ws_allowin), 32'd1);
    check($sformatf("v%0d_pc", idx), bus.ws_pc, v.pc);
    step();
    @(negedge clk);
    check($sformatf("v%0d_idle_we", idx), 32'(bus.rf_we), 32'd0);
    step();
  endtask

  function automatic vec_t mk(input logic [2:0] ld, input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [31:0] ext, input logic [4:0] src,
                              input logic [2:0] dst, input logic [4:0] rd, input logic [4:0] rt,
                              input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    vec_t v;
    v.ld = ld; v.pc = pc; v.alu = alu; v.mem = mem; v.ext = ext; v.src = src;
    v.dst = dst; v.rd = rd; v.rt = rt; v.we = we; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  // Reference load extraction by shifting and masking the word.
  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  logic [2:0]  r_ld, r_dst;
  logic [31:0] r_pc, r_alu, r_mem, r_ext, part;
  logic [4:0]  r_src, r_rd, r_rt, r_addr;
  logic        pend, acc;
  int          issued, writes, cycles;
  exp_t        e;

  initial begin
    resetn = 1'b0;
    bus.ms_to_ws_valid = 1'b0;
    bus.md_ready = 1'b0;
    bus.md_data = 32'd0;
    drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 5'd0, 5'd0);

    vecs.push_back(mk(3'd1, 32'h0, 32'h1003, 32'h80FF_1234, 32'h0, 5'h01, 3'b010, 5'd0, 5'd8, 1'b1, 5'd8, 32'hFFFF_FF80));
    vecs.push_back(mk(3'd2, 32'h0, 32'h1003, 32'h80FF_1234, 32'h0, 5'h01, 3'b010, 5'd0, 5'd8, 1'b1, 5'd8, 32'h0000_0080));
    vecs.push_back(mk(3'd0, 32'hBFC0_0100, 32'h0, 32'h0, 32'h0, 5'h04, 3'b100, 5'd0, 5'd0, 1'b1, 5'd31, 32'hBFC0_0108));
    vecs.push_back(mk(3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 5'h04, 3'b100, 5'd0, 5'd0, 1'b1, 5'd31, 32'h0000_0004));
    vecs.push_back(mk(3'd0, 32'h40, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'h02, 3'b001, 5'd0, 5'd7, 1'b0, 5'd0, 32'hDEAD_BEEF));
    vecs.push_back(mk(3'd3, 32'h0, 32'h1002, 32'h80FF_1234, 32'h0, 5'h01, 3'b001, 5'd9, 5'd0, 1'b1, 5'd9, 32'hFFFF_80FF));
    vecs.push_back(mk(3'd4, 32'h0, 32'h1003, 32'h80FF_1234, 32'h0, 5'h01, 3'b001, 5'd9, 5'd0, 1'b1, 5'd9, 32'h0000_80FF));
    vecs.push_back(mk(3'd3, 32'h0, 32'h1001, 32'h80FF_1234, 32'h0, 5'h01, 3'b001, 5'd9, 5'd0, 1'b1, 5'd9, 32'h0000_1234));
    vecs.push_back(mk(3'd0, 32'h0, 32'h1000, 32'h80FF_1234, 32'h0, 5'h01, 3'b001, 5'd2, 5'd0, 1'b1, 5'd2, 32'h80FF_1234));
    vecs.push_back(mk(3'd1, 32'h0, 32'h1001, 32'h80FF_1234, 32'h0, 5'h01, 3'b001, 5'd2, 5'd0, 1'b1, 5'd2, 32'h0000_0012));
    vecs.push_back(mk(3'd7, 32'h0, 32'h1001, 32'h80FF_1234, 32'h0, 5'h01, 3'b001, 5'd2, 5'd0, 1'b1, 5'd2, 32'h80FF_1234));
    vecs.push_back(mk(3'd0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 5'h10, 3'b010, 5'd0, 5'd17, 1'b1, 5'd17, 32'hCAFE_F00D));
    vecs.push_back(mk(3'd0, 32'h1000, 32'h00F0, 32'h0, 32'h0, 5'h06, 3'b001, 5'd4, 5'd0, 1'b1, 5'd4, 32'h0000_10F8));
    vecs.push_back(mk(3'd0, 32'h0, 32'h5, 32'h0, 32'h0, 5'h02, 3'b011, 5'd1, 5'd2, 1'b1, 5'd3, 32'h0000_0005));

    step();
    step();
    check("rst_we", 32'(bus.rf_we), 32'd0);
    check("rst_fwd_valid", 32'(bus.ws_fwd_valid), 32'd0);
    check("rst_allowin", 32'(bus.ws_allowin), 32'd1);
    check("rst_pc", bus.ws_pc, 32'd0);
    resetn = 1'b1;
    step();

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // MFHI waiting three cycles for md_ready.
    drive(3'd0, 32'h200, 32'h0, 32'h0, 32'h0, 5'h08, 3'b001, 5'd3, 5'd0);
    bus.ms_to_ws_valid = 1'b1;
    step();
    bus.ms_to_ws_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("md_wait%0d_allowin", i), 32'(bus.ws_allowin), 32'd0);
      check($sformatf("md_wait%0d_fwd_valid", i), 32'(bus.ws_fwd_valid), 32'd1);
      check($sformatf("md_wait%0d_fwd_ok", i), 32'(bus.ws_fwd_ok), 32'd0);
      check($sformatf("md_wait%0d_we", i), 32'(bus.rf_we), 32'd0);
      step();
    end
    bus.md_ready = 1'b1;
    bus.md_data = 32'h1357_2468;
    @(negedge clk);
    check("md_ret_we", 32'(bus.rf_we), 32'd1);
    check("md_ret_waddr", 32'(bus.rf_waddr), 32'd3);
    check("md_ret_wdata", bus.rf_wdata, 32'h1357_2468);
    check("md_ret_fwd_ok", 32'(bus.ws_fwd_ok), 32'd1);
    check("md_ret_allowin", 32'(bus.ws_allowin), 32'd1);
    step();
    bus.md_ready = 1'b0;
    @(negedge clk);
    check("md_after_we", 32'(bus.rf_we), 32'd0);
    check("md_after_fwd_valid", 32'(bus.ws_fwd_valid), 32'd0);
    step();

    // Four back-to-back ALU instructions.
    drive(3'd0, 32'h300, 32'h100, 32'h0, 32'h0, 5'h02, 3'b001, 5'd10, 5'd0);
    bus.ms_to_ws_valid = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) drive(3'd0, 32'h300 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 32'h0, 5'h02, 3'b001, 5'(10 + i), 5'd0);
      else bus.ms_to_ws_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d_we", i), 32'(bus.rf_we), 32'd1);
      check($sformatf("b2b%0d_waddr", i), 32'(bus.rf_waddr), 32'(10 + i - 1));
      check($sformatf("b2b%0d_wdata", i), bus.rf_wdata, 32'h100 + 32'(i - 1));
      check($sformatf("b2b%0d_allowin", i), 32'(bus.ws_allowin), 32'd1);
      step();
    end
    @(negedge clk);
    check("b2b_end_we", 32'(bus.rf_we), 32'd0);
    step();

    // Reset while an MFHI waits, then md_ready pulses.
    drive(3'd0, 32'h400, 32'h0, 32'h0, 32'h0, 5'h08, 3'b001, 5'd6, 5'd0);
    bus.ms_to_ws_valid = 1'b1;
    step();
    bus.ms_to_ws_valid = 1'b0;
    step();
    resetn = 1'b0;
    #1;
    check("mrst_we", 32'(bus.rf_we), 32'd0);
    check("mrst_fwd_valid", 32'(bus.ws_fwd_valid), 32'd0);
    check("mrst_allowin", 32'(bus.ws_allowin), 32'd1);
    check("mrst_pc", bus.ws_pc, 32'd0);
    bus.md_ready = 1'b1;
    bus.md_data = 32'hAAAA_5555;
    step();
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("mrst_md_we", 32'(bus.rf_we), 32'd0);
    check("mrst_md_fwd_valid", 32'(bus.ws_fwd_valid), 32'd0);
    step();
    bus.md_ready = 1'b0;
    apply_vec(vecs[2], 100);

    // Randomized stream against the reference model.
    pend = 1'b0; acc = 1'b0; issued = 0; writes = 0; cycles = 0;
    r_ld = '0; r_dst = '0; r_pc = '0; r_alu = '0; r_mem = '0; r_ext = '0;
    r_src = '0; r_rd = '0; r_rt = '0;
    while ((issued < 300 || pend || expq.size() != 0) && cycles < 20000) begin
      if (pend && acc) begin
        r_addr = 5'd0;
        if (r_dst[0]) r_addr = r_addr | r_rd;
        if (r_dst[1]) r_addr = r_addr | r_rt;
        if (r_dst[2]) r_addr = r_addr | 5'd31;
        part = 32'd0;
        if (r_src[0]) part = part | m_load(r_ld, r_alu[1:0], r_mem);
        if (r_src[1]) part = part | r_alu;
        if (r_src[2]) part = part | (r_pc + 32'd8);
        if (r_src[4]) part = part | r_ext;
        if (r_dst != 3'd0 && r_addr != 5'd0) begin
          e.addr = r_addr; e.data = part; e.md = r_src[3];
          expq.push_back(e);
        end
        pend = 1'b0;
      end
      if (!pend && issued < 300 && $urandom_range(0, 3) != 0) begin
        r_ld = 3'($urandom_range(0, 7));
        r_pc = $urandom; r_alu = $urandom; r_mem = $urandom; r_ext = $urandom;
        r_src = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'(1 << $urandom_range(0, 4));
        r_dst = 3'($urandom_range(0, 7));
        r_rd = 5'($urandom_range(0, 31)); r_rt = 5'($urandom_range(0, 31));
        pend = 1'b1;
        issued++;
      end
      drive(r_ld, r_pc, r_alu, r_mem, r_ext, r_src, r_dst, r_rd, r_rt);
      bus.ms_to_ws_valid = pend;
      bus.md_ready = ($urandom_range(0, 2) == 0);
      bus.md_data = $urandom;
      @(negedge clk);
      acc = pend && bus.ws_allowin;
      if (bus.rf_we) begin
        writes++;
        if (expq.size() == 0) begin
          check("rand_unexpected_we", 32'(bus.rf_we), 32'd0);
        end else begin
          e = expq.pop_front();
          check("rand_waddr", 32'(bus.rf_waddr), 32'(e.addr));
          check("rand_wdata", bus.rf_wdata, e.md ? (e.data | bus.md_data) : e.data);
        end
      end
      step();
      cycles++;
    end
    bus.ms_to_ws_valid = 1'b0;
    check("rand_timeout", 32'(cycles < 20000), 32'd1);
    check("rand_drained", 32'(expq.size()), 32'd0);
    check("rand_some_writes", 32'(writes > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
